// File: rtl/gpu_pkg.sv
// Shared GPU column-buffer definitions: screen geometry, writer FSM states, packed column record.
// Latency: none. Backpressure: none.
package gpu_pkg;

   localparam int SCREEN_COLUMNS = 320;
   localparam int COLUMN_ADDR_W  = 9;
   localparam int COLUMN_DATA_W  = 16;

   localparam logic [COLUMN_DATA_W-1:0] CLEAR_DISTANCE = 16'hFFFF;
   localparam logic [COLUMN_ADDR_W-1:0] COL_LIMIT      = COLUMN_ADDR_W'(SCREEN_COLUMNS);
   localparam logic [COLUMN_ADDR_W-1:0] COL_LAST       = COLUMN_ADDR_W'(SCREEN_COLUMNS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SWAP    = 2'd2,
      ST_CLEAR   = 2'd3
   } col_state_e;

   typedef struct packed {
      logic [COLUMN_DATA_W-1:0] distance;
      logic [COLUMN_DATA_W-1:0] texture;
   } column_rec_t;

endpackage

// File: rtl/column_buffer_writer_if.sv
// CPU write port, swap control, vsync and renderer read port of the column buffer.
// Latency: none. Backpressure: cpu_ready qualifies cpu_we.
interface column_buffer_writer_if;
   import gpu_pkg::*;

   logic [COLUMN_ADDR_W-1:0] cpu_addr;
   logic [COLUMN_DATA_W-1:0] cpu_distance;
   logic [COLUMN_DATA_W-1:0] cpu_texture;
   logic                     cpu_we;
   logic                     cpu_ready;
   logic                     swap_req;
   logic                     swap_pending;
   logic                     v_sync;
   logic [COLUMN_ADDR_W-1:0] reading_index;
   logic [COLUMN_DATA_W-1:0] distance;
   logic [COLUMN_DATA_W-1:0] texture;
   logic                     buffer_select;

   modport master (
      output cpu_addr, cpu_distance, cpu_texture, cpu_we, swap_req, v_sync, reading_index,
      input  cpu_ready, swap_pending, distance, texture, buffer_select
   );

   modport slave (
      input  cpu_addr, cpu_distance, cpu_texture, cpu_we, swap_req, v_sync, reading_index,
      output cpu_ready, swap_pending, distance, texture, buffer_select
   );

endinterface

// File: rtl/column_ram.sv
// Simple dual-port RAM, one write port and one registered read port, written for block-RAM inference.
// Latency: 1 clk read. Backpressure: none.
module column_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/column_buffer_writer.sv
// Double-buffered column store: CPU fills the back half, renderer reads the front half, halves swap at vsync.
// Latency: 1 clk read. Backpressure: cpu_ready low only while the COLUMN_AUTO_CLEAR_EN sweep runs.
module column_buffer_writer
   import gpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  clr,
   column_buffer_writer_if.slave bus
);

   col_state_e                 state_q, state_d;
   logic                       bs_q, bs_d;
   logic                       v_sync_q, v_sync_d;
   logic                       rd_zero_q, rd_zero_d;
   logic                       vsync_evt;
   logic                       ram_we;
   logic [COLUMN_ADDR_W:0]     ram_waddr;
   logic [COLUMN_ADDR_W:0]     ram_raddr;
   column_rec_t                ram_wdata;
   column_rec_t                ram_rdata;
`ifdef COLUMN_AUTO_CLEAR_EN
   logic [COLUMN_ADDR_W-1:0]   sweep_q, sweep_d;
`endif

   // The half select is the top RAM address bit; the back half is always ~bs_q.
   always_comb begin
      state_d   = state_q;
      bs_d      = bs_q;
      v_sync_d  = bus.v_sync;
      rd_zero_d = (bus.reading_index >= COL_LIMIT);
      vsync_evt = v_sync_q & ~bus.v_sync;
      ram_raddr = {bs_q, bus.reading_index};
      ram_waddr = {~bs_q, bus.cpu_addr};
      ram_wdata = '{distance: bus.cpu_distance, texture: bus.cpu_texture};
      ram_we    = bus.cpu_we && (state_q != ST_CLEAR) && (bus.cpu_addr < COL_LIMIT);
`ifdef COLUMN_AUTO_CLEAR_EN
      sweep_d   = sweep_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.swap_req) begin
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (vsync_evt) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            bs_d = ~bs_q;
`ifdef COLUMN_AUTO_CLEAR_EN
            state_d = ST_CLEAR;
            sweep_d = '0;
`else
            state_d = ST_IDLE;
`endif
         end
`ifdef COLUMN_AUTO_CLEAR_EN
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = {~bs_q, sweep_q};
            ram_wdata = '{distance: CLEAR_DISTANCE, texture: '0};
            if (sweep_q == COL_LAST) begin
               state_d = ST_IDLE;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clr) begin
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         bs_q      <= 1'b0;
         v_sync_q  <= 1'b1;
         rd_zero_q <= 1'b1;
`ifdef COLUMN_AUTO_CLEAR_EN
         sweep_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         bs_q      <= bs_d;
         v_sync_q  <= v_sync_d;
         rd_zero_q <= rd_zero_d;
`ifdef COLUMN_AUTO_CLEAR_EN
         sweep_q   <= sweep_d;
`endif
      end
   end

   column_ram #(
      .ADDR_W (COLUMN_ADDR_W + 1),
      .DATA_W (2 * COLUMN_DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Out-of-range reads and the post-reset cycle return zero rather than RAM contents.
   assign bus.distance      = rd_zero_q ? '0 : ram_rdata.distance;
   assign bus.texture       = rd_zero_q ? '0 : ram_rdata.texture;
   assign bus.cpu_ready     = (state_q != ST_CLEAR);
   assign bus.swap_pending  = (state_q == ST_PENDING) || (state_q == ST_SWAP);
   assign bus.buffer_select = bs_q;

endmodule

// File: tb/tb_column_buffer_writer.sv
// Bench for column_buffer_writer: directed scenarios plus random traffic against a two-array frame model.
module tb_column_buffer_writer;
   import gpu_pkg::*;

   logic clk = 1'b0;
   logic clr;
   int   n_assert = 0;
   int   n_fail   = 0;

   column_buffer_writer_if bus_if();

   column_buffer_writer dut (
      .clk (clk),
      .clr (clr),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   // Reference: two halves as plain arrays, a front index, a pending flag and a one-cycle swap flag.
   logic [31:0] m_mem   [2][SCREEN_COLUMNS];
   bit          m_known [2][SCREEN_COLUMNS];
   bit          m_sel, m_pend, m_swap, m_vprev;
   int          m_clear;
   logic [15:0] e_dist, e_tex;
   bit          e_known;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit evt;
      int idx;
      if (clr) begin
         m_sel = 0; m_pend = 0; m_swap = 0; m_vprev = 1; m_clear = 0;
         e_dist = 0; e_tex = 0; e_known = 1;
         return;
      end
      evt     = m_vprev && !bus_if.v_sync;
      m_vprev = bus_if.v_sync;
      idx     = int'(bus_if.reading_index);
      if (idx >= SCREEN_COLUMNS) begin
         e_dist = 0; e_tex = 0; e_known = 1;
      end else begin
         e_dist  = m_mem[m_sel][idx][31:16];
         e_tex   = m_mem[m_sel][idx][15:0];
         e_known = m_known[m_sel][idx];
      end
      if (m_clear > 0) begin
         m_mem[!m_sel][SCREEN_COLUMNS - m_clear]   = {CLEAR_DISTANCE, 16'h0000};
         m_known[!m_sel][SCREEN_COLUMNS - m_clear] = 1;
         m_clear--;
      end else if (bus_if.cpu_we && int'(bus_if.cpu_addr) < SCREEN_COLUMNS) begin
         m_mem[!m_sel][bus_if.cpu_addr]   = {bus_if.cpu_distance, bus_if.cpu_texture};
         m_known[!m_sel][bus_if.cpu_addr] = 1;
      end
      if (m_swap) begin
         m_sel  = !m_sel;
         m_swap = 0;
`ifdef COLUMN_AUTO_CLEAR_EN
         m_clear = SCREEN_COLUMNS;
`endif
      end else if (m_pend && evt) begin
         m_pend = 0;
         m_swap = 1;
      end else if (!m_pend && m_clear == 0 && bus_if.swap_req) begin
         m_pend = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("swap_pending", 32'(bus_if.swap_pending), 32'(m_pend || m_swap));
      chk("buffer_select", 32'(bus_if.buffer_select), 32'(m_sel));
      chk("cpu_ready", 32'(bus_if.cpu_ready), 32'(m_clear == 0));
      if (e_known) begin
         chk("distance", 32'(bus_if.distance), 32'(e_dist));
         chk("texture", 32'(bus_if.texture), 32'(e_tex));
      end
   endtask

   task automatic write_col(input int addr, input logic [31:0] rec);
      bus_if.cpu_we       = 1'b1;
      bus_if.cpu_addr     = COLUMN_ADDR_W'(addr);
      bus_if.cpu_distance = rec[31:16];
      bus_if.cpu_texture  = rec[15:0];
      step();
      bus_if.cpu_we = 1'b0;
   endtask

   task automatic pulse_swap_req();
      bus_if.swap_req = 1'b1;
      step();
      bus_if.swap_req = 1'b0;
   endtask

   // Falling edge, then the swap cycle, then vsync back high.
   task automatic vsync_pulse();
      bus_if.v_sync = 1'b0;
      step();
      step();
      bus_if.v_sync = 1'b1;
      step();
   endtask

   initial begin
      logic [31:0] rec;
      bit          sel_before;
      int          busy;

      foreach (m_known[h, i]) m_known[h][i] = 0;
      clr = 1'b1;
      bus_if.cpu_we = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_distance = '0; bus_if.cpu_texture = '0;
      bus_if.swap_req = 1'b0; bus_if.v_sync = 1'b1; bus_if.reading_index = '0;
      step();
      step();
      clr = 1'b0;
      chk("reset_bs", 32'(bus_if.buffer_select), 32'h0);
      chk("reset_dist", 32'(bus_if.distance), 32'h0);
      chk("reset_ready", 32'(bus_if.cpu_ready), 32'h1);

      // Basic write, swap, read back from the new front.
      write_col(5, {16'h0100, 16'h0023});
      pulse_swap_req();
      step();
      chk("t1_pending", 32'(bus_if.swap_pending), 32'h1);
      vsync_pulse();
      bus_if.reading_index = 9'd5;
      step();
      chk("t1_bs", 32'(bus_if.buffer_select), 32'h1);
      chk("t1_dist", 32'(bus_if.distance), 32'h0100);
      chk("t1_tex", 32'(bus_if.texture), 32'h0023);

      // Long wait with no vsync; repeated requests must not queue a second toggle.
      bus_if.reading_index = 9'd400;
      for (int i = 0; i < 1000; i++) begin
         bus_if.swap_req = (i % 100 == 0);
         step();
      end
      bus_if.swap_req = 1'b0;
      chk("t2_pending", 32'(bus_if.swap_pending), 32'h1);
      chk("t2_bs_hold", 32'(bus_if.buffer_select), 32'h1);
      vsync_pulse();
      step();
      chk("t2_bs_once", 32'(bus_if.buffer_select), 32'h0);
      chk("t2_idle", 32'(bus_if.swap_pending), 32'h0);

      // Fill both halves so every later read has a known expectation.
      for (int h = 0; h < 2; h++) begin
         for (int a = 0; a < SCREEN_COLUMNS; a++) write_col(a, $urandom);
         pulse_swap_req();
         vsync_pulse();
      end
      for (int a = 0; a < SCREEN_COLUMNS; a++) write_col(a, $urandom);

      // Out-of-range write is dropped and out-of-range read returns zero.
      write_col(320, {16'hAAAA, 16'h5555});
      bus_if.reading_index = 9'd320;
      step();
      chk("t3_oob_dist", 32'(bus_if.distance), 32'h0);
      chk("t3_oob_tex", 32'(bus_if.texture), 32'h0);
      bus_if.reading_index = 9'd0;
      step();

      // Write landing in the exact swap cycle shows up in the new front.
      pulse_swap_req();
      bus_if.v_sync = 1'b0;
      step();
      write_col(7, {16'hBEEF, 16'h0031});
      bus_if.v_sync = 1'b1;
      bus_if.reading_index = 9'd7;
      step();
      chk("t4_dist", 32'(bus_if.distance), 32'hBEEF);
      chk("t4_tex", 32'(bus_if.texture), 32'h0031);
      for (int i = 0; i < 330; i++) step();

      // Reset while a swap is pending cancels it.
      pulse_swap_req();
      chk("t5_pending", 32'(bus_if.swap_pending), 32'h1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t5_pend_clr", 32'(bus_if.swap_pending), 32'h0);
      chk("t5_bs_clr", 32'(bus_if.buffer_select), 32'h0);
      vsync_pulse();
      chk("t5_no_toggle", 32'(bus_if.buffer_select), 32'h0);

      // Request and vsync event together: swap waits for the following vsync.
      bus_if.swap_req = 1'b1;
      bus_if.v_sync   = 1'b0;
      step();
      bus_if.swap_req = 1'b0;
      step();
      step();
      chk("t6_waiting", 32'(bus_if.swap_pending), 32'h1);
      chk("t6_bs_hold", 32'(bus_if.buffer_select), 32'h0);
      bus_if.v_sync = 1'b1;
      step();
      vsync_pulse();
      chk("t6_bs_toggled", 32'(bus_if.buffer_select), 32'h1);

`ifdef COLUMN_AUTO_CLEAR_EN
      for (int i = 0; i < 330; i++) step();
      pulse_swap_req();
      bus_if.v_sync = 1'b0;
      step();
      step();
      bus_if.v_sync = 1'b1;
      busy = 0;
      for (int i = 0; i < 400; i++) begin
         if (!bus_if.cpu_ready) busy++;
         step();
      end
      chk("clear_busy_cycles", 32'(busy), 32'd320);
      pulse_swap_req();
      vsync_pulse();
      for (int i = 0; i < 340; i++) begin
         bus_if.reading_index = COLUMN_ADDR_W'(i % SCREEN_COLUMNS);
         step();
      end
`endif

      // Random traffic checked cycle by cycle against the model.
      sel_before = bus_if.buffer_select;
      for (int i = 0; i < 3000; i++) begin
         rec = $urandom;
         bus_if.cpu_we        = ($urandom_range(0, 1) == 1);
         bus_if.cpu_addr      = COLUMN_ADDR_W'($urandom_range(0, 335));
         bus_if.cpu_distance  = rec[31:16];
         bus_if.cpu_texture   = rec[15:0];
         bus_if.swap_req      = ($urandom_range(0, 19) == 0);
         bus_if.v_sync        = ($urandom_range(0, 40) != 0);
         bus_if.reading_index = COLUMN_ADDR_W'($urandom_range(0, 330));
         step();
      end
      bus_if.cpu_we = 1'b0;
      bus_if.swap_req = 1'b0;
      bus_if.v_sync = 1'b1;
      step();
      if (bus_if.buffer_select == sel_before) $display("note: random phase ended on the starting half");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
